ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Consumes the PS/2 scan-code byte stream from PS2Receiver (keycode[7:0] + oflag) and decodes
//  make/break/extended sequences into a held-key bitmap and a press/release event stream for the
//  game controls. Sits between PS2Receiver and the game logic, in parallel with the UART debug path.
// PARAMETERS
//  NKEYS          12  tracked keys; fixed by the key table in ps2_key_pkg
//  REPEAT_FILTER  1   1: typematic repeat makes of an already-held key produce no event
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-low reset
//  byte_in      in   8      latest scan-code byte (PS2Receiver keycode[7:0])
//  byte_valid   in   1      PS2Receiver oflag; may stay high >1 cycle, only its rising edge counts
//  key_state    out  NKEYS  1 = key currently held
//  ev_valid     out  1      event pending
//  ev_key       out  4      key index of the pending event
//  ev_press     out  1      1 = make, 0 = break
//  ev_ready     in   1      consumer accepts the event when ev_valid & ev_ready
//  ev_overflow  out  1      sticky: an event was dropped because one was pending
// BEHAVIOUR
//  Reset (rst=0, async): key_state=0, ev_valid=0, ev_key=0, ev_press=0, ev_overflow=0, FSM=IDLE.
//  Strobe: byte_valid registered once; strobe = byte_valid & ~byte_valid_q; byte_in taken on strobe.
//  All outputs registered; key_state/ev_* change on the clk edge that processes the strobe.
//  FSM (advances on strobe only):
//   IDLE:  E0->EXT; F0->BRK; E1->SKIP (cnt=7); other byte b -> MAKE(normal b), IDLE
//   EXT:   F0->EXT_BRK; E0/E1 -> restart as in IDLE; other b -> MAKE(ext b), IDLE
//   BRK:   b -> BREAK(normal b), IDLE
//   EXT_BRK: b -> BREAK(ext b), IDLE
//   SKIP:  cnt decrements per byte; cnt 1->0 returns to IDLE; Pause sequence never affects keys
//  MAKE(k): unmapped -> ignored. Mapped idx i: set key_state[i]; raise event (i,1) unless
//   REPEAT_FILTER=1 and key_state[i] already 1.
//  BREAK(k): unmapped -> ignored. Mapped i: clear key_state[i]; event (i,0) only if it was held.
//  Extended 12 (fake shift, E0 12 / E0 F0 12) is unmapped and ignored.
//  Event slot (one entry): new event with ev_valid=0 loads slot. With ev_valid=1 and ev_ready=1
//   in the same cycle, new event replaces the slot (ev_valid stays 1). ev_valid=1, ev_ready=0:
//   new event dropped, ev_overflow<=1 (cleared only by reset). key_state is updated regardless.
//  ev_valid & ~ev_ready: ev_key/ev_press stable. ev_valid falls the cycle after handshake.
//  Bytes AA/FA/EE/FE in IDLE: ignored (no key effect). Reset mid-sequence returns FSM to IDLE.
// CONFIGURATION
//  OVERRUN_CLR_EN defined: byte 00 or FF in any state -> FSM=IDLE, key_state cleared to 0 in
//   one cycle, no events emitted, pending event retained. Not defined: 00/FF treated as an
//   ordinary unmapped code (make in IDLE, ignored).
// STRUCTURE
//  ps2_key_pkg: scan-code constants (E0,E1,F0,AA,FA), FSM state encoding, key index constants,
//   table: 0 Up E0_75, 1 Down E0_72, 2 Left E0_6B, 3 Right E0_74, 4 W 1D, 5 A 1C, 6 S 1B,
//   7 D 23, 8 Space 29, 9 Enter 5A, 10 Esc 76, 11 P 4D.
//  Sub-module ps2_key_lookup: combinational {ext,byte} -> {hit, idx[3:0]}.
// TESTING
//  Bytes 1D; F0 1D, ev_ready=1 -> key_state[4] 1 then 0; events (4,1),(4,0).
//  Bytes E0 75 x3 (repeat), REPEAT_FILTER=1 -> key_state[0]=1, exactly one event (0,1).
//  Bytes E1 14 77 E1 F0 14 F0 77 then 29 -> no change from Pause; then (8,1), key_state[8]=1.
//  ev_ready=0; bytes 1C, 1B -> ev_key=5 held, ev_overflow=1, key_state[6:5]=2'b11.
//  byte_valid held high 3 cycles with 29 -> single make event; rst low mid E0 F0 -> all zero.
//  OVERRUN_CLR_EN: keys 4,8 held, byte FF -> key_state=0 next cycle, no new event.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
//  Shared definitions for the PS/2 key tracker: scan-code constants, the
//  decoder state encoding, the tracked-key index table and a helper that
//  recognises keyboard-to-host reply bytes.
//  The optional overrun-clear behaviour in ps2_key_tracker is enabled by
//  defining OVERRUN_CLR_EN; the constants it needs live here regardless.
package ps2_key_pkg;

  localparam int NKEYS_TBL = 12;

  // Prefix and special scan-code bytes
  localparam logic [7:0] SC_E0 = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_E1 = 8'hE1;  // Pause prefix
  localparam logic [7:0] SC_F0 = 8'hF0;  // break prefix
  localparam logic [7:0] SC_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] SC_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] SC_EE = 8'hEE;  // echo
  localparam logic [7:0] SC_FE = 8'hFE;  // resend
  localparam logic [7:0] SC_00 = 8'h00;  // keyboard buffer overrun (set 2)
  localparam logic [7:0] SC_FF = 8'hFF;  // keyboard buffer overrun / error

  // Bytes still to swallow after E1: the rest of "E1 14 77 E1 F0 14 F0 77"
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_t;

  // Tracked key indices (bit positions in key_state)
  localparam logic [3:0] KEY_UP    = 4'd0;   // E0 75
  localparam logic [3:0] KEY_DOWN  = 4'd1;   // E0 72
  localparam logic [3:0] KEY_LEFT  = 4'd2;   // E0 6B
  localparam logic [3:0] KEY_RIGHT = 4'd3;   // E0 74
  localparam logic [3:0] KEY_W     = 4'd4;   // 1D
  localparam logic [3:0] KEY_A     = 4'd5;   // 1C
  localparam logic [3:0] KEY_S     = 4'd6;   // 1B
  localparam logic [3:0] KEY_D     = 4'd7;   // 23
  localparam logic [3:0] KEY_SPACE = 4'd8;   // 29
  localparam logic [3:0] KEY_ENTER = 4'd9;   // 5A
  localparam logic [3:0] KEY_ESC   = 4'd10;  // 76
  localparam logic [3:0] KEY_P     = 4'd11;  // 4D

  // True for keyboard status/reply bytes: self-test, ack, echo, resend
  function automatic logic is_host_reply(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_EE) || (b == SC_FE);
  endfunction

endpackage

// File: rtl/ps2_key_lookup.sv
// ps2_key_lookup
//  Combinational scan-code to key-index table.
//  Ports:
//    ext   in  1  code was preceded by E0
//    code  in  8  scan-code byte (without prefixes)
//    hit   out 1  code is one of the tracked keys
//    idx   out 4  key index (0 when hit=0)
//  Extended 12 (the fake shift sent around cursor keys) is deliberately absent.
module ps2_key_lookup
  import ps2_key_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] idx
);

  always_comb begin
    hit = 1'b1;
    idx = 4'd0;
    if (ext) begin
      case (code)
        8'h75:   idx = KEY_UP;
        8'h72:   idx = KEY_DOWN;
        8'h6B:   idx = KEY_LEFT;
        8'h74:   idx = KEY_RIGHT;
        default: hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1D:   idx = KEY_W;
        8'h1C:   idx = KEY_A;
        8'h1B:   idx = KEY_S;
        8'h23:   idx = KEY_D;
        8'h29:   idx = KEY_SPACE;
        8'h5A:   idx = KEY_ENTER;
        8'h76:   idx = KEY_ESC;
        8'h4D:   idx = KEY_P;
        default: hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//  Decodes the PS/2 set-2 scan-code byte stream (make / F0 break / E0 extended
//  / E1 Pause) into a held-key bitmap and a one-deep press/release event slot.
//  Ports:
//    clk          in   1      system clock
//    rst          in   1      asynchronous, active-low reset
//    byte_in      in   8      latest scan-code byte
//    byte_valid   in   1      byte strobe level; only its rising edge counts
//    key_state    out  NKEYS  1 = key currently held
//    ev_valid     out  1      event pending
//    ev_key       out  4      key index of the pending event
//    ev_press     out  1      1 = make, 0 = break
//    ev_ready     in   1      consumer takes the event when ev_valid & ev_ready
//    ev_overflow  out  1      sticky: an event was dropped while one was pending
//  Configuration: define OVERRUN_CLR_EN to make 00/FF bytes abort any sequence
//  and release all keys (no events); otherwise 00/FF are ordinary unmapped codes.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int NKEYS         = NKEYS_TBL,
  parameter int REPEAT_FILTER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [NKEYS-1:0] key_state,
  output logic             ev_valid,
  output logic [3:0]       ev_key,
  output logic             ev_press,
  input  logic             ev_ready,
  output logic             ev_overflow
);

  logic             byte_valid_q, byte_valid_d;
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [NKEYS-1:0] key_state_q, key_state_d;
  logic             ev_valid_q, ev_valid_d;
  logic [3:0]       ev_key_q, ev_key_d;
  logic             ev_press_q, ev_press_d;
  logic             ev_overflow_q, ev_overflow_d;

  logic             strobe;
  logic             overrun;
  logic             lk_ext;
  logic             lk_hit;
  logic [3:0]       lk_idx;
  logic             do_make, do_break;
  logic             new_ev, new_press;
  logic             held;

  assign byte_valid_d = byte_valid;
  assign strobe       = byte_valid & ~byte_valid_q;

`ifdef OVERRUN_CLR_EN
  assign overrun = strobe & ((byte_in == SC_00) | (byte_in == SC_FF));
`else
  assign overrun = 1'b0;
`endif

  // The E0 prefix is remembered in the state, so the lookup sees it directly.
  assign lk_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

  ps2_key_lookup u_lookup (
    .ext  (lk_ext),
    .code (byte_in),
    .hit  (lk_hit),
    .idx  (lk_idx)
  );

  // Sequence decoder
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    if (overrun) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          if (byte_in == SC_E0) begin
            state_d = ST_EXT;
          end else if (byte_in == SC_E1) begin
            state_d = ST_SKIP;
            cnt_d   = PAUSE_TAIL;
          end else if (byte_in == SC_F0) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else begin
            state_d = ST_IDLE;
            do_make = !((state_q == ST_IDLE) && is_host_reply(byte_in));
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d  = ST_IDLE;
          do_break = 1'b1;
        end
        ST_SKIP: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Key bitmap and event generation
  always_comb begin
    key_state_d = key_state_q;
    new_ev      = 1'b0;
    new_press   = 1'b0;
    held        = key_state_q[lk_idx];
    if (do_make && lk_hit) begin
      key_state_d[lk_idx] = 1'b1;
      // A typematic repeat of a key already down is not a new press
      new_ev    = !((REPEAT_FILTER != 0) && held);
      new_press = 1'b1;
    end
    if (do_break && lk_hit) begin
      key_state_d[lk_idx] = 1'b0;
      new_ev              = held;
    end
    if (overrun) begin
      key_state_d = '0;
    end
  end

  // One-entry event slot; a handshake in the same cycle frees it for the new event
  always_comb begin
    ev_valid_d    = ev_valid_q & ~ev_ready;
    ev_key_d      = ev_key_q;
    ev_press_d    = ev_press_q;
    ev_overflow_d = ev_overflow_q;
    if (new_ev) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d = 1'b1;
        ev_key_d   = lk_idx;
        ev_press_d = new_press;
      end else begin
        ev_overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_valid_q  <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      key_state_q   <= '0;
      ev_valid_q    <= 1'b0;
      ev_key_q      <= 4'd0;
      ev_press_q    <= 1'b0;
      ev_overflow_q <= 1'b0;
    end else begin
      byte_valid_q  <= byte_valid_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      ev_valid_q    <= ev_valid_d;
      ev_key_q      <= ev_key_d;
      ev_press_q    <= ev_press_d;
      ev_overflow_q <= ev_overflow_d;
    end
  end

  assign key_state   = key_state_q;
  assign ev_valid    = ev_valid_q;
  assign ev_key      = ev_key_q;
  assign ev_press    = ev_press_q;
  assign ev_overflow = ev_overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//  Directed and randomized byte streams for ps2_key_tracker. A reference model
//  decodes the stream with plain prefix flags and code-to-key tables; outputs
//  are compared every cycle on the falling clock edge. Build with
//  +define+OVERRUN_CLR_EN to exercise the overrun-clear variant.
module tb_ps2_key_tracker;

  localparam int NK  = 12;
  localparam bit REP = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          ev_ready = 1'b0;
  logic [NK-1:0] key_state;
  logic          ev_valid;
  logic [3:0]    ev_key;
  logic          ev_press;
  logic          ev_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.NKEYS(NK), .REPEAT_FILTER(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .key_state   (key_state),
    .ev_valid    (ev_valid),
    .ev_key      (ev_key),
    .ev_press    (ev_press),
    .ev_ready    (ev_ready),
    .ev_overflow (ev_overflow)
  );

  // ---------------- reference model ----------------
  int norm_map[256];
  int ext_map[256];
  bit m_held[NK];
  bit m_ev_valid, m_ev_press, m_ovf, m_bv_prev;
  int m_ev_key;
  bit m_ext, m_brk;
  int m_skip;
  bit m_new, m_new_press;
  int m_new_key;

  typedef struct packed {
    logic [3:0] key;
    logic       press;
  } ev_t;
  ev_t seen[$];   // events the bench consumer actually took from the DUT

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_ev_valid = 0; m_ev_press = 0; m_ovf = 0; m_bv_prev = 0; m_ev_key = 0;
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  function automatic logic [NK-1:0] model_keys();
    logic [NK-1:0] v;
    for (int i = 0; i < NK; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic model_key(input bit ext, input logic [7:0] b, input bit make);
    int i;
    i = ext ? ext_map[b] : norm_map[b];
    if (i < 0) return;
    if (make) begin
      if (!(REP && m_held[i])) begin m_new = 1; m_new_key = i; m_new_press = 1; end
      m_held[i] = 1;
    end else begin
      if (m_held[i]) begin m_new = 1; m_new_key = i; m_new_press = 0; end
      m_held[i] = 0;
    end
  endtask

  task automatic model_decode(input logic [7:0] b);
`ifdef OVERRUN_CLR_EN
    if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
      foreach (m_held[i]) m_held[i] = 1'b0;
      return;
    end
`endif
    if (m_skip > 0) begin m_skip--; return; end
    if (m_brk) begin model_key(m_ext, b, 0); m_ext = 0; m_brk = 0; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hE1) begin m_ext = 0; m_skip = 7; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    model_key(m_ext, b, 1);
    m_ext = 0;
  endtask

  task automatic model_edge(input bit bv, input logic [7:0] b, input bit rdy);
    bit strobe, was;
    strobe = bv && !m_bv_prev;
    was = m_ev_valid;
    m_bv_prev = bv;
    m_new = 0;
    if (was && rdy) m_ev_valid = 0;
    if (strobe) model_decode(b);
    if (m_new) begin
      if (!was || rdy) begin
        m_ev_valid = 1; m_ev_key = m_new_key; m_ev_press = m_new_press;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("key_state", 32'(key_state), 32'(model_keys()));
    chk("ev_valid", 32'(ev_valid), 32'(m_ev_valid));
    chk("ev_key", 32'(ev_key), 32'(m_ev_key));
    chk("ev_press", 32'(ev_press), 32'(m_ev_press));
    chk("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
  endtask

  // One clock: called at a falling edge, drives inputs for the next rising edge,
  // then checks the outputs at the following falling edge.
  task automatic cycle(input bit bv, input logic [7:0] b, input bit rdy);
    ev_t e;
    if (ev_valid && rdy) begin
      e.key = ev_key; e.press = ev_press;
      seen.push_back(e);
    end
    byte_valid = bv; byte_in = b; ev_ready = rdy;
    model_edge(bv, b, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input int hold, input bit rdy);
    $display("byte %02h hold=%0d ready=%0b", b, hold, rdy);
    repeat (hold) cycle(1'b1, b, rdy);
    cycle(1'b0, b, rdy);
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_key_state", 32'(key_state), 32'd0);
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_key", 32'(ev_key), 32'd0);
    chk("rst_ev_press", 32'(ev_press), 32'd0);
    chk("rst_ev_overflow", 32'(ev_overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    $display("reset");
  endtask

  logic [7:0]    pool[24];
  logic [7:0]    pause_seq[8];
  logic [NK-1:0] ks_before;

  initial begin
    for (int i = 0; i < 256; i++) begin norm_map[i] = -1; ext_map[i] = -1; end
    ext_map[8'h75] = 0; ext_map[8'h72] = 1; ext_map[8'h6B] = 2; ext_map[8'h74] = 3;
    norm_map[8'h1D] = 4; norm_map[8'h1C] = 5; norm_map[8'h1B] = 6; norm_map[8'h23] = 7;
    norm_map[8'h29] = 8; norm_map[8'h5A] = 9; norm_map[8'h76] = 10; norm_map[8'h4D] = 11;
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h4D, 8'h75, 8'h72,
             8'h6B, 8'h74, 8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA,
             8'hFA, 8'h12, 8'h00, 8'hFF};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    model_reset();

    #2;
    do_reset();

    // make then break of W with a ready consumer
    send(8'h1D, 1, 1'b1);
    chk("w_held", 32'(key_state[4]), 32'd1);
    send(8'hF0, 1, 1'b1);
    send(8'h1D, 1, 1'b1);
    chk("w_released", 32'(key_state[4]), 32'd0);
    chk("w_ev_count", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("w_ev0", 32'(seen[0]), 32'h09);   // key 4, press
      chk("w_ev1", 32'(seen[1]), 32'h08);   // key 4, release
    end

    // typematic repeat of Up produces a single press event
    seen.delete();
    repeat (3) begin send(8'hE0, 1, 1'b1); send(8'h75, 1, 1'b1); end
    chk("up_held", 32'(key_state[0]), 32'd1);
    chk("up_ev_count", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) chk("up_ev0", 32'(seen[0]), 32'h01);
    send(8'hE0, 1, 1'b1); send(8'hF0, 1, 1'b1); send(8'h75, 1, 1'b1);

    // Pause is swallowed, the byte after it decodes normally
    seen.delete();
    ks_before = key_state;
    foreach (pause_seq[i]) send(pause_seq[i], 1, 1'b1);
    chk("pause_keys", 32'(key_state), 32'(ks_before));
    chk("pause_ev_count", 32'(seen.size()), 32'd0);
    send(8'h29, 1, 1'b1);
    chk("space_held", 32'(key_state[8]), 32'd1);
    chk("space_ev_count", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) chk("space_ev0", 32'(seen[0]), 32'h11);

    // randomized stream against the model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 23)];
      send(b, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    end

    // blocked consumer: second press is dropped, first stays stable
    do_reset();
    send(8'h1C, 1, 1'b0);
    send(8'h1B, 1, 1'b0);
    chk("ovf_ev_valid", 32'(ev_valid), 32'd1);
    chk("ovf_ev_key", 32'(ev_key), 32'd5);
    chk("ovf_ev_press", 32'(ev_press), 32'd1);
    chk("ovf_flag", 32'(ev_overflow), 32'd1);
    chk("ovf_keys", 32'(key_state[6:5]), 32'd3);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_drained", 32'(ev_valid), 32'd0);

    // long byte_valid pulse counts once
    do_reset();
    seen.delete();
    send(8'h29, 3, 1'b1);
    chk("hold_ev_count", 32'(seen.size()), 32'd1);
    send(8'hF0, 1, 1'b1);
    send(8'h29, 3, 1'b1);
    chk("hold_release", 32'(key_state[8]), 32'd0);
    chk("hold_ev_count2", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) chk("hold_ev1", 32'(seen[1]), 32'h10);

    // reset in the middle of E0 F0 returns the decoder to idle
    send(8'hE0, 1, 1'b1);
    send(8'hF0, 1, 1'b1);
    do_reset();
    send(8'h1D, 1, 1'b1);
    chk("post_rst_make", 32'(key_state[4]), 32'd1);

    // overrun byte with keys 4 and 8 held
    send(8'h29, 1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    seen.delete();
    send(8'hFF, 1, 1'b1);
`ifdef OVERRUN_CLR_EN
    chk("overrun_keys", 32'(key_state), 32'd0);
`else
    chk("overrun_keys", 32'(key_state), 32'h110);
`endif
    chk("overrun_ev_count", 32'(seen.size()), 32'd0);
    chk("overrun_ev_valid", 32'(ev_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
